// File: rtl/csa_pipe.sv
// Two-stage pipelined carry-skip adder with valid/ready handshake; latency 2 edges, stalls hold both stages.
// Define CSA_PIPE_APPROX_EN to honour `approx`, which cuts carries out of the low APPROX_BLKS blocks.
module csa_pipe #(
  parameter int WIDTH       = 16,
  parameter int BLK         = 3,
  parameter int APPROX_BLKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int NB = (WIDTH + BLK - 1) / BLK;

  logic             v1, v2, stall;
  logic [WIDTH-1:0] a_q, b_q, s_d;
  logic             ci_q, ax_q, ax_d;
  logic [NB-1:0]    p_d, g_d, p_q, g_q;
  logic [NB:0]      c;

  assign stall     = v2 & ~out_ready;
  assign in_ready  = ~(v1 & stall);
  assign out_valid = v2;
  assign c[0]      = ci_q;

`ifdef CSA_PIPE_APPROX_EN
  assign ax_d = approx;
`else
  assign ax_d = 1'b0;
  logic unused_ax;
  assign unused_ax = ax_q ^ approx;
`endif

  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int LO = k * BLK;
    localparam int HI = (LO + BLK > WIDTH) ? WIDTH - 1 : LO + BLK - 1;
    localparam int W  = HI - LO + 1;

    logic [W:0] gen_sum_unused;
    logic       cut;

    // Block generate/propagate are formed with a zero carry-in so stage 2 only resolves the skip chain.
    assign gen_sum_unused = {1'b0, a[HI:LO]} + {1'b0, b[HI:LO]};
    assign g_d[k]         = gen_sum_unused[W];
    assign p_d[k]         = &(a[HI:LO] ^ b[HI:LO]);

`ifdef CSA_PIPE_APPROX_EN
    assign cut = ax_q && (k < APPROX_BLKS);
`else
    assign cut = 1'b0;
`endif

    assign c[k+1]     = ~cut & (g_q[k] | (p_q[k] & c[k]));
    assign s_d[HI:LO] = a_q[HI:LO] + b_q[HI:LO] + W'(c[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      ci_q <= 1'b0;
      ax_q <= 1'b0;
      p_q  <= '0;
      g_q  <= '0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        a_q  <= a;
        b_q  <= b;
        ci_q <= ci;
        ax_q <= ax_d;
        p_q  <= p_d;
        g_q  <= g_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      s  <= '0;
      co <= 1'b0;
    end else if (!stall) begin
      v2 <= v1;
      if (v1) begin
        s  <= s_d;
        co <= c[NB];
      end
    end
  end

endmodule

// File: tb/tb_csa_pipe.sv
// Bench for csa_pipe: directed vectors on a 16/3/2 instance plus exact-mode random sweeps on four geometries.
module tb_csa_pipe;

`ifdef CSA_PIPE_APPROX_EN
  localparam bit AX_ON = 1'b1;
`else
  localparam bit AX_ON = 1'b0;
`endif
  localparam int NSW = 2500;

  logic        clk = 1'b0;
  logic        rst_n, rst_sw, in_valid, in_ready, ci, approx, out_valid, out_ready, co;
  logic [15:0] a, b, s;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  csa_pipe #(.WIDTH(16), .BLK(3), .APPROX_BLKS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .approx(approx),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co)
  );

  function automatic logic [63:0] msk(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: plain addition, or independent low segments plus an uncarried upper part.
  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic c, input logic ax,
                                        input int w, input int blk, input int ab);
    logic [63:0] r, seg;
    int          lo;
    if (!ax) return (x + y + 64'(c)) & msk(w + 1);
    r = '0;
    for (int k = 0; k < ab; k++) begin
      seg = ((x >> (k * blk)) & msk(blk)) + ((y >> (k * blk)) & msk(blk)) + ((k == 0) ? 64'(c) : 64'd0);
      r   = r | ((seg & msk(blk)) << (k * blk));
    end
    lo = ab * blk;
    r  = r | (((x >> lo) + (y >> lo)) << lo);
    return r & msk(w + 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard for the main instance.
  logic [63:0] exp_q[$];
  initial begin : cmp_main
    logic        hold;
    logic [63:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        hold = 1'b0;
      end else begin
        if (hold && out_valid) chk("hold_stable", 64'({co, s}), held);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("stray_out_valid", 64'(out_valid), 64'd0);
          else                   chk("sum_main", 64'({co, s}), exp_q.pop_front());
        end
        if (in_valid && in_ready)
          exp_q.push_back(model(64'(a), 64'(b), ci, approx && AX_ON, 16, 3, 2));
        hold = out_valid && !out_ready;
        held = 64'({co, s});
      end
    end
  end

  task automatic present(input logic [15:0] aa, input logic [15:0] bb, input logic cc, input logic ax);
    int t;
    a = aa; b = bb; ci = cc; approx = ax; in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        chk("accept_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_one(input string name, input logic [15:0] aa, input logic [15:0] bb,
                          input logic cc, input logic ax, input logic [15:0] es, input logic ec);
    present(aa, bb, cc, ax);
    chk({name, "_vld_edge_n"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({name, "_vld_edge_n1"}, 64'(out_valid), 64'd1);
    chk({name, "_s"}, 64'(s), 64'(es));
    chk({name, "_co"}, 64'(co), 64'(ec));
    @(posedge clk); #1;
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int W  = (gi == 0) ? 16 : (gi == 1) ? 32 : (gi == 2) ? 8 : 13;
    localparam int B  = (gi == 0) ? 3  : (gi == 1) ? 4  : (gi == 2) ? 8 : 5;
    localparam int AB = (gi == 2) ? 0 : 2;

    logic         iv, ir, cc, ov, orr, cw;
    logic [W-1:0] aa, bb, ss;
    logic [63:0]  q[$];
    int           sent = 0;
    bit           done = 1'b0;

    csa_pipe #(.WIDTH(W), .BLK(B), .APPROX_BLKS(AB)) u_sw (
      .clk(clk), .rst_n(rst_sw), .in_valid(iv), .in_ready(ir),
      .a(aa), .b(bb), .ci(cc), .approx(1'b0),
      .out_valid(ov), .out_ready(orr), .s(ss), .co(cw)
    );

    initial begin : drv
      bit hs;
      iv = 1'b0; orr = 1'b0; aa = '0; bb = '0; cc = 1'b0;
      @(posedge rst_sw);
      @(posedge clk); #1;
      while (sent < NSW) begin
        @(negedge clk);
        hs = iv && ir;
        @(posedge clk); #1;
        if (hs) sent++;
        if (hs || !iv) begin
          iv = (sent < NSW) && ($urandom_range(3) != 0);
          aa = W'($urandom());
          bb = W'($urandom());
          cc = 1'($urandom());
        end
        orr = ($urandom_range(3) != 0);
      end
      iv  = 1'b0;
      orr = 1'b1;
    end

    initial begin : cmp
      forever begin
        @(negedge clk);
        if (ov && orr) begin
          if (q.size() == 0) chk($sformatf("sw%0d_stray", gi), 64'(ov), 64'd0);
          else               chk($sformatf("sw%0d_sum", gi), 64'({cw, ss}), q.pop_front());
        end
        if (iv && ir) q.push_back((64'(aa) + 64'(bb) + 64'(cc)) & msk(W + 1));
        done = (sent == NSW) && (q.size() == 0);
      end
    end
  end

  initial begin
    rst_sw = 1'b0;
    #23 rst_sw = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; approx = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_co", 64'(co), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Exact-mode vectors.
    send_one("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    send_one("cin_skip",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0);
    send_one("max_sum",   16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);

    // Approximate-mode vectors: low two 3-bit blocks drop their carries.
    send_one("apx_cut",   16'h003F, 16'h0001, 1'b0, 1'b1, AX_ON ? 16'h0038 : 16'h0040, 1'b0);
    send_one("apx_off",   16'h003F, 16'h0001, 1'b0, 1'b0, 16'h0040, 1'b0);
    send_one("apx_top",   16'hFFFF, 16'h0001, 1'b0, 1'b1, AX_ON ? 16'hFFF8 : 16'h0000, !AX_ON);
    send_one("apx_cin",   16'h0005, 16'h0002, 1'b1, 1'b1, AX_ON ? 16'h0000 : 16'h0008, 1'b0);

    // Backpressure: four beats against a four-cycle stall.
    out_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        present(16'd1, 16'd1, 1'b0, 1'b0);
        present(16'd2, 16'd2, 1'b0, 1'b0);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_first_s", 64'(s), 64'd2);
        @(posedge clk); #1;
        chk("bp_s_held", 64'(s), 64'd2);
        chk("bp_vld_held", 64'(out_valid), 64'd1);
        present(16'd3, 16'd3, 1'b0, 1'b0);
        present(16'd4, 16'd4, 1'b0, 1'b0);
      end
      begin
        int got;
        got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            got++;
            chk($sformatf("bp_out%0d", got), 64'(s), 64'(2 * got));
          end
        end
        chk("bp_count", 64'(got), 64'd4);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Reset with two beats in flight.
    present(16'd1, 16'd1, 1'b0, 1'b0);
    present(16'd2, 16'd2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_s", 64'(s), 64'd0);
    chk("mid_rst_co", 64'(co), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_one("post_rst", 16'd5, 16'd6, 1'b0, 1'b0, 16'd11, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_stale", 64'(out_valid), 64'd0);
    end

    t = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && t < 40000) begin
      @(posedge clk);
      t++;
    end
    chk("sweep0_done", 64'(g_sw[0].done), 64'd1);
    chk("sweep1_done", 64'(g_sw[1].done), 64'd1);
    chk("sweep2_done", 64'(g_sw[2].done), 64'd1);
    chk("sweep3_done", 64'(g_sw[3].done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
